// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one pipelined 64x64 multiplier among NUM_REQ requesters.
// Optional build macro MULT_ARB_STATS_EN adds saturating grant/stall counters (stat_issued, stat_stall).
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 8,
    parameter int ID_W    = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*64-1:0] req_mcand,
    input  logic [NUM_REQ*64-1:0] req_mplier,
    output logic                  mult_start,
    output logic [63:0]           mult_mcand,
    output logic [63:0]           mult_mplier,
    input  logic                  mult_done,
    input  logic [63:0]           mult_product,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [63:0]           resp_product,
    output logic                  err_spurious
`ifdef MULT_ARB_STATS_EN
    ,
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_stall
`endif
);
    localparam int PTR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic             grant;
    logic [ID_W-1:0]  tag_mem [LATENCY];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] flush_cnt;
    logic             fifo_full;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LATENCY - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full = (count == CNT_W'(LATENCY));
    assign pop       = mult_done && (count != '0);

    // Handshake: a request transfers when req_valid[i] & req_ready[i] are both high at the
    // rising edge. req_ready depends combinationally on req_valid, so a requester keeps
    // valid and its operands stable until it sees ready; there is no backpressure on responses.
    always_comb begin
        grant     = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        if (!fifo_full) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                    grant    = 1'b1;
                    grant_id = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
                end
            end
            if (grant) req_ready[grant_id] = 1'b1;
        end
    end

    // Issue side: round-robin pointer and registered operands to the multiplier.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr      <= '0;
            mult_start  <= 1'b0;
            mult_mcand  <= '0;
            mult_mplier <= '0;
        end else begin
            mult_start <= grant;
            if (grant) begin
                rr_ptr      <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
                mult_mcand  <= req_mcand[int'(grant_id)*64 +: 64];
                mult_mplier <= req_mplier[int'(grant_id)*64 +: 64];
            end
        end
    end

    // Tag storage carries no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clock) begin
        if (grant) tag_mem[wr_ptr] <= grant_id;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({grant, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Response routing and spurious-done detection; the flush window hides done pulses
    // belonging to operations that were in the multiplier when reset hit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid   <= '0;
            resp_product <= '0;
            err_spurious <= 1'b0;
            flush_cnt    <= CNT_W'(LATENCY);
        end else begin
            resp_valid <= '0;
            if (pop) begin
                resp_valid   <= NUM_REQ'(1) << tag_mem[rd_ptr];
                resp_product <= mult_product;
            end
            if (mult_done && (count == '0) && (flush_cnt == '0)) err_spurious <= 1'b1;
            if (flush_cnt != '0) flush_cnt <= flush_cnt - 1'b1;
        end
    end

`ifdef MULT_ARB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (grant && (stat_issued != 32'hFFFF_FFFF)) stat_issued <= stat_issued + 1'b1;
            if (!grant && (|req_valid) && (stat_stall != 32'hFFFF_FFFF)) stat_stall <= stat_stall + 1'b1;
        end
    end
`endif

endmodule
